// File: rtl/fetch_unit.sv
// PC, base-address register and CALL/RET return stack for the single-cycle CPU.
// Zero-latency fetch: prog_addr is the live PC; all state moves on the next rising edge.
module fetch_unit #(
  parameter int WIDTH    = 8,
  parameter int LR_DEPTH = 4,
  parameter int SP_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  halt,
  input  logic                  pc_rst,
  input  logic                  pc_ld,
  input  logic [1:0]            jmp_mode,
  input  logic [WIDTH-1:0]      base_reg_offset,
  input  logic                  base_reg_ld,
  input  logic [WIDTH-1:0]      base_reg_data,
  input  logic                  lr_ld,
  input  logic [2*WIDTH-1:0]    prog_data,
  output logic [WIDTH-1:0]      prog_addr,
  output logic [WIDTH-1:0]      instr,
  output logic [WIDTH-1:0]      arg,
  output logic [WIDTH-1:0]      bar_q,
  output logic [WIDTH-1:0]      lr_top,
  output logic [SP_WIDTH-1:0]   sp,
  output logic                  stk_ovf,
  output logic                  stk_unf
);

  localparam int                  IDX_W    = (LR_DEPTH > 1) ? $clog2(LR_DEPTH) : 1;
  localparam logic [SP_WIDTH-1:0] DEPTH_SP = SP_WIDTH'(LR_DEPTH);
  localparam logic [SP_WIDTH-1:0] SP_ONE   = SP_WIDTH'(1);
  localparam logic [1:0]          JMP_ABS  = 2'b00;
  localparam logic [1:0]          JMP_BAR  = 2'b01;
  localparam logic [1:0]          JMP_RET  = 2'b11;

  logic [WIDTH-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0]    bar_d;
  logic [SP_WIDTH-1:0] sp_q, sp_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;
  logic [WIDTH-1:0]    stk_q [LR_DEPTH];

  logic [SP_WIDTH-1:0] sp_dec;
  logic [SP_WIDTH-1:0] sp_pop;
  logic [IDX_W-1:0]    top_idx;
  logic [IDX_W-1:0]    push_idx;
  logic                push_en;
  logic                stk_nz;

  assign stk_nz  = (sp_q != '0);
  assign sp_dec  = sp_q - SP_ONE;
  assign top_idx = sp_dec[IDX_W-1:0];
  assign lr_top  = stk_nz ? stk_q[top_idx] : '0;

  always_comb begin
    pc_d     = pc_q + WIDTH'(1);
    bar_d    = bar_q;
    sp_d     = sp_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    sp_pop   = sp_q;
    push_en  = 1'b0;
    push_idx = '0;

    if (pc_rst) begin
      pc_d  = '0;
      bar_d = '0;
      sp_d  = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end else if (halt) begin
      pc_d = pc_q;
    end else begin
      // jmp_mode 10 is reserved and falls through to a plain increment
      if (pc_ld) begin
        case (jmp_mode)
          JMP_ABS: pc_d = base_reg_offset;
          JMP_BAR: pc_d = bar_q + base_reg_offset;
          JMP_RET: begin
            if (stk_nz) begin
              pc_d   = lr_top + base_reg_offset;
              sp_pop = sp_dec;
            end else begin
              unf_d = 1'b1;
            end
          end
          default: ;
        endcase
      end

      // Push lands after any same-cycle pop, so CALL+RET reuses the popped slot.
      sp_d = sp_pop;
      if (lr_ld) begin
        if (sp_pop < DEPTH_SP) begin
          push_en  = 1'b1;
          push_idx = sp_pop[IDX_W-1:0];
          sp_d     = sp_pop + SP_ONE;
        end else begin
          ovf_d = 1'b1;
        end
      end

      if (base_reg_ld) begin
        bar_d = base_reg_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= '0;
      bar_q <= '0;
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < LR_DEPTH; i++) begin
        stk_q[i] <= '0;
      end
    end else begin
      pc_q  <= pc_d;
      bar_q <= bar_d;
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (push_en) begin
        stk_q[push_idx] <= pc_q;
      end
    end
  end

  assign prog_addr = pc_q;
  assign instr     = prog_data[2*WIDTH-1:WIDTH];
  assign arg       = prog_data[WIDTH-1:0];
  assign sp        = sp_q;
  assign stk_ovf   = ovf_q;
  assign stk_unf   = unf_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: queue-based return-stack model, directed scenarios then random traffic.
module tb_fetch_unit;

  localparam int W   = 8;
  localparam int D   = 4;
  localparam int SPW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           halt, pc_rst, pc_ld, base_reg_ld, lr_ld;
  logic [1:0]     jmp_mode;
  logic [W-1:0]   base_reg_offset, base_reg_data;
  logic [2*W-1:0] prog_data;
  logic [W-1:0]   prog_addr, instr, arg, bar_q, lr_top;
  logic [SPW-1:0] sp;
  logic           stk_ovf, stk_unf;

  fetch_unit #(.WIDTH(W), .LR_DEPTH(D), .SP_WIDTH(SPW)) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .pc_rst(pc_rst), .pc_ld(pc_ld),
    .jmp_mode(jmp_mode), .base_reg_offset(base_reg_offset), .base_reg_ld(base_reg_ld),
    .base_reg_data(base_reg_data), .lr_ld(lr_ld), .prog_data(prog_data),
    .prog_addr(prog_addr), .instr(instr), .arg(arg), .bar_q(bar_q), .lr_top(lr_top),
    .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0]   pc;
    logic [W-1:0]   bar;
    logic [W-1:0]   top;
    logic [SPW-1:0] sp;
    logic           ovf;
    logic           unf;
    logic [W-1:0]   ins;
    logic [W-1:0]   arg;
  } obs_t;

  obs_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: architectural state with the return stack as a plain queue.
  logic [W-1:0] m_pc, m_bar;
  logic [W-1:0] m_stk[$];
  logic         m_ovf, m_unf;

  function automatic obs_t model_obs(input logic [2*W-1:0] pd);
    obs_t o;
    o.pc  = m_pc;
    o.bar = m_bar;
    o.top = (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : '0;
    o.sp  = SPW'(m_stk.size());
    o.ovf = m_ovf;
    o.unf = m_unf;
    o.ins = pd[2*W-1:W];
    o.arg = pd[W-1:0];
    return o;
  endfunction

  task automatic m_reset();
    m_pc = '0; m_bar = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic m_step();
    logic [W-1:0] npc;
    logic [W-1:0] old_pc;
    old_pc = m_pc;
    npc    = m_pc + 8'd1;
    if (pc_rst) begin
      m_reset();
    end else if (!halt) begin
      if (pc_ld) begin
        case (jmp_mode)
          2'b00: npc = base_reg_offset;
          2'b01: npc = m_bar + base_reg_offset;
          2'b11: begin
            if (m_stk.size() > 0) npc = m_stk.pop_back() + base_reg_offset;
            else m_unf = 1'b1;
          end
          default: ;
        endcase
      end
      if (lr_ld) begin
        if (m_stk.size() < D) m_stk.push_back(old_pc);
        else m_ovf = 1'b1;
      end
      if (base_reg_ld) m_bar = base_reg_data;
      m_pc = npc;
    end
  endtask

  // Applied at a falling edge: record the expected outputs for this cycle, advance the model, wait one cycle.
  task automatic cyc(input logic h, input logic pr, input logic pl, input logic [1:0] jm,
                     input logic [W-1:0] off, input logic bl, input logic [W-1:0] bd,
                     input logic ll, input logic [2*W-1:0] pd);
    halt = h; pc_rst = pr; pc_ld = pl; jmp_mode = jm; base_reg_offset = off;
    base_reg_ld = bl; base_reg_data = bd; lr_ld = ll; prog_data = pd;
    exp_q.push_back(model_obs(pd));
    if (!rst_n) m_reset();
    else m_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0, 16'(($urandom())));
  endtask

  task automatic jmp(input logic [1:0] jm, input logic [W-1:0] off);
    cyc(0, 0, 1, jm, off, 0, 8'h00, 0, 16'h1234);
  endtask

  task automatic call(input logic [W-1:0] tgt);
    cyc(0, 0, 1, 2'b00, tgt, 0, 8'h00, 1, 16'hC0DE);
  endtask

  task automatic ret(input logic [W-1:0] off);
    cyc(0, 0, 1, 2'b11, off, 0, 8'h00, 0, 16'hBEEF);
  endtask

  // Monitor: every cycle the DUT presents a fetch, so one expectation is consumed per falling edge.
  initial begin
    obs_t got, exp;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {prog_addr, bar_q, lr_top, sp, stk_ovf, stk_unf, instr, arg};
        n_vec++;
        if (got !== exp) begin
          n_err++;
          $display("FAIL cycle_obs t=%0t got pc=%h bar=%h top=%h sp=%0d ovf=%b unf=%b ins=%h arg=%h exp pc=%h bar=%h top=%h sp=%0d ovf=%b unf=%b ins=%h arg=%h",
                   $time, got.pc, got.bar, got.top, got.sp, got.ovf, got.unf, got.ins, got.arg,
                   exp.pc, exp.bar, exp.top, exp.sp, exp.ovf, exp.unf, exp.ins, exp.arg);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    halt = 0; pc_rst = 0; pc_ld = 0; jmp_mode = 2'b00; base_reg_offset = '0;
    base_reg_ld = 0; base_reg_data = '0; lr_ld = 0; prog_data = 16'hA512;
    m_reset();
    @(negedge clk);

    // Reset state, then three idle fetches with a fixed word
    cyc(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0, 16'hA512);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0, 16'hA512);
    idle(2);

    // Asynchronous reset in the middle of a cycle must clear the PC without a clock edge
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if (prog_addr !== 8'h00 || sp !== 3'd0 || bar_q !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset got pc=%h sp=%0d bar=%h exp pc=00 sp=0 bar=00", prog_addr, sp, bar_q);
    end
    m_reset();
    @(negedge clk);
    cyc(0, 0, 0, 2'b00, 8'h00, 0, 8'h00, 0, 16'hA512);
    rst_n = 1'b1;

    // PC wrap and pc_rst
    cyc(0, 0, 0, 2'b00, 8'h00, 1, 8'h33, 0, 16'h0000);
    jmp(2'b00, 8'hFE);
    idle(3);
    jmp(2'b00, 8'h05);
    cyc(0, 1, 0, 2'b00, 8'h00, 0, 8'h00, 0, 16'h0505);
    idle(1);

    // BAR-relative jumps, including wrap and same-cycle BAR load
    cyc(0, 0, 0, 2'b00, 8'h00, 1, 8'h40, 0, 16'h0000);
    jmp(2'b01, 8'h05);
    idle(1);
    cyc(0, 0, 0, 2'b00, 8'h00, 1, 8'hF0, 0, 16'h0000);
    jmp(2'b01, 8'h20);
    idle(1);
    cyc(0, 0, 0, 2'b00, 8'h00, 1, 8'h40, 0, 16'h0000);
    cyc(0, 0, 1, 2'b01, 8'h01, 1, 8'h80, 0, 16'h0000);
    idle(1);

    // Single CALL/RET, reserved mode
    jmp(2'b00, 8'h10);
    call(8'h30);
    ret(8'h01);
    jmp(2'b10, 8'h99);
    idle(1);

    // Nested calls beyond the stack depth, then unwind past empty
    for (int i = 0; i < 5; i++) call(8'(8'h50 + 8'(i * 16)));
    idle(1);
    for (int i = 0; i < 5; i++) ret(8'h01);
    idle(1);

    // Push and pop in the same cycle
    call(8'h20);
    cyc(0, 0, 1, 2'b11, 8'h02, 0, 8'h00, 1, 16'h0000);
    idle(1);

    // Halt freezes everything; pc_rst still wins under halt
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 2'b00, 8'h77, 1, 8'h12, 1, 16'h5A5A);
    idle(2);
    cyc(1, 1, 0, 2'b00, 8'h00, 0, 8'h00, 0, 16'h0000);
    idle(1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(15) == 0), ($urandom_range(40) == 0), ($urandom_range(2) == 0),
          2'($urandom_range(3)), 8'($urandom()), ($urandom_range(3) == 0), 8'($urandom()),
          ($urandom_range(3) == 0), 16'($urandom()));
    end

    @(negedge clk);
    @(negedge clk);
    #4;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter and fetch stage of the one-cycle CPU. It drives the program memory address, splits the fetched word into instr/arg for the instruction decoder, and consumes the decoder's control outputs: pc_rst, pc_ld, jmp_mode, base_reg_offset, base_reg_ld, base_reg_data and lr_ld. It owns the PC, the base address register (BAR) and a small link-register return stack used by CALL/RET.

Parameters:
WIDTH, 8, data/address width; PC, BAR and stack entries are WIDTH bits.
LR_DEPTH, 4, return-stack entries (power of 2, minimum 2).
SP_WIDTH, 3, stack-count width; must satisfy LR_DEPTH <= 2^SP_WIDTH - 1.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
halt  in  1  freezes all state while high; pc_rst still acts.
pc_rst  in  1  synchronous PC reset request from the decoder.
pc_ld  in  1  load the jump target this cycle.
jmp_mode  in  2  00 absolute/CALL, 01 BAR-relative, 11 RET, 10 reserved.
base_reg_offset  in  WIDTH  jump offset, or absolute target.
base_reg_ld  in  1  load BAR from base_reg_data.
base_reg_data  in  WIDTH  new BAR value.
lr_ld  in  1  push the current PC onto the return stack (CALL).
prog_data  in  2*WIDTH  program memory read data, combinational with prog_addr.
prog_addr  out  WIDTH  current PC.
instr  out  WIDTH  prog_data[2*WIDTH-1:WIDTH].
arg  out  WIDTH  prog_data[WIDTH-1:0].
bar_q  out  WIDTH  current BAR.
lr_top  out  WIDTH  top stack entry; 0 when the stack is empty.
sp  out  SP_WIDTH  number of valid stack entries.
stk_ovf  out  1  sticky flag: push attempted while the stack is full.
stk_unf  out  1  sticky flag: RET attempted while the stack is empty.

Behaviour:
- Reset (async, rst_n=0) clears PC, BAR, sp, stk_ovf, stk_unf and all stack entries to 0. instr/arg are pure combinational slices of prog_data and have no reset value.
- Fetch is zero latency: prog_addr equals PC and the instruction executes in the same cycle; state updates on the next rising edge.
- Next-PC priority:
  1) pc_rst=1: PC<=0, BAR<=0, sp<=0, flags cleared. This applies even when halt=1.
  2) halt=1: no state changes.
  3) pc_ld=1, jmp_mode=00: PC<=base_reg_offset.
  4) pc_ld=1, jmp_mode=01: PC<=BAR+base_reg_offset, mod 2^WIDTH, using the BAR value before any same-cycle update.
  5) pc_ld=1, jmp_mode=11, sp>0: PC<=lr_top+base_reg_offset, mod 2^WIDTH; sp decrements.
  6) pc_ld=1, jmp_mode=11, sp=0: PC<=PC+1; stk_unf<=1.
  7) pc_ld=1, jmp_mode=10: treated as no jump, PC<=PC+1.
  8) otherwise: PC<=PC+1, wrapping 0xFF->0x00 for WIDTH=8.
- CALL (lr_ld=1 and pc_ld=1, not halted, no pc_rst):
  - Pushes the current PC, i.e. the CALL's own address, so RET with offset 1 resumes at CALL+1.
  - If sp<LR_DEPTH: stack[sp]<=PC, sp<=sp+1.
  - If sp=LR_DEPTH: push dropped, stack unchanged, stk_ovf<=1. The jump is still taken.
- lr_ld=1 with pc_ld=0: push happens as above and PC increments.
- lr_ld=1 together with jmp_mode=11 (push and pop in one cycle): the pop uses the old top, then the push writes the old top slot; sp is unchanged.
- base_reg_ld=1: BAR<=base_reg_data, independent of the jump logic. A same-cycle JMPO uses the old BAR.
- stk_ovf and stk_unf clear only on reset or pc_rst.
- lr_top = stack[sp-1] when sp>0, else 0.

Test Plan:
- Reset, then 3 idle cycles -> prog_addr 0,1,2; instr/arg track prog_data=16'hA512 as A5/12; rst_n low mid-cycle -> prog_addr=0 immediately.
- PC=8'hFE with no jumps -> FE, FF, 00 (wrap). At PC=05, pc_rst=1 -> next PC=0, BAR=0.
- base_reg_ld with data 8'h40, next cycle JMPO offset 8'h05 -> PC=8'h45. BAR 8'hF0 with offset 8'h20 -> PC=8'h10. Simultaneous BAR load 8'h80 and JMPO offset 1 with old BAR 8'h40 -> PC=8'h41.
- At PC=8'h10, CALL 8'h30 -> PC=30, sp=1, lr_top=10. Then RET (offset 1) -> PC=11, sp=0.
- Five nested CALLs with LR_DEPTH=4 -> sp stays 4 and stk_ovf=1. The fifth jump is still taken. Four RETs unwind correctly. A fifth RET -> PC+1 and stk_unf=1.
- halt=1 for 3 cycles during a JMP request -> PC, BAR and sp frozen. halt=1 with pc_rst=1 -> PC=0.
